// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 writeback register file with load formatting, same-cycle bypass and a write counter.
module wb_regfile (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  WB_control,
    input  logic [4:0]  RegDst,
    input  logic [31:0] ReadData,
    input  logic [31:0] ALUResult,
    input  logic [4:0]  RS1_addr,
    input  logic [4:0]  RS2_addr,
    output logic [31:0] RS1_data,
    output logic [31:0] RS2_data,
    output logic        WB_wen,
    output logic [4:0]  WB_dst,
    output logic [31:0] WB_data,
    output logic [31:0] WriteCount
);
    logic [31:0] regs_q [32];
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] load_fmt;
    logic        unused_ctl;
    assign unused_ctl = WB_control[4];
    always_comb begin
        load_fmt = WB_control[1:0] == 2'b00 ? ReadData :
                   WB_control[1:0] == 2'b01 ? {{24{ReadData[7]}}, ReadData[7:0]} :
                   WB_control[1:0] == 2'b10 ? {{16{ReadData[15]}}, ReadData[15:0]} :
                                              {24'h0, ReadData[7:0]};
        WB_data  = WB_control[2] ? load_fmt : ALUResult;
        WB_wen   = WB_control[3] && (RegDst != 5'd0);
        WB_dst   = RegDst;
        cnt_d    = cnt_q + 32'd1;
        // x0 reads as zero regardless of any pending write; otherwise the pending write wins
        RS1_data = RS1_addr == 5'd0 ? 32'h0 : (WB_wen && RS1_addr == RegDst) ? WB_data : regs_q[RS1_addr];
        RS2_data = RS2_addr == 5'd0 ? 32'h0 : (WB_wen && RS2_addr == RegDst) ? WB_data : regs_q[RS2_addr];
    end
    assign WriteCount = cnt_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
            cnt_q <= 32'h0;
        end else if (WB_wen) begin
            regs_q[RegDst] <= WB_data;
            cnt_q          <= cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed checks of wb_regfile against a behavioural register-file model.
module tb_wb_regfile;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  WB_control, RegDst, RS1_addr, RS2_addr;
    logic [31:0] ReadData, ALUResult;
    logic [31:0] RS1_data, RS2_data, WB_data, WriteCount;
    logic        WB_wen;
    logic [4:0]  WB_dst;

    int checks = 0;
    int failures = 0;
    logic [31:0] mregs [32];
    logic [31:0] mcnt;

    wb_regfile dut (
        .CLK(CLK), .RESET(RESET), .WB_control(WB_control), .RegDst(RegDst),
        .ReadData(ReadData), .ALUResult(ALUResult), .RS1_addr(RS1_addr), .RS2_addr(RS2_addr),
        .RS1_data(RS1_data), .RS2_data(RS2_data), .WB_wen(WB_wen), .WB_dst(WB_dst),
        .WB_data(WB_data), .WriteCount(WriteCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_wb();
        logic [31:0] r;
        r = ReadData;
        if (!WB_control[2]) return ALUResult;
        case (WB_control[1:0])
            2'b00: return r;
            2'b01: return (r & 32'hFF) | (r[7] ? 32'hFFFF_FF00 : 32'h0);
            2'b10: return (r & 32'hFFFF) | (r[15] ? 32'hFFFF_0000 : 32'h0);
            default: return r & 32'hFF;
        endcase
    endfunction

    function automatic logic m_wen();
        return WB_control[3] && RegDst != 0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_wen() && a == RegDst) return m_wb();
        return RESET ? 32'h0 : mregs[a];
    endfunction

    task automatic compare_all();
        chk("wb_wen", {31'h0, WB_wen}, {31'h0, m_wen()});
        chk("wb_dst", {27'h0, WB_dst}, {27'h0, RegDst});
        chk("wb_data", WB_data, m_wb());
        chk("rs1_data", RS1_data, m_rd(RS1_addr));
        chk("rs2_data", RS2_data, m_rd(RS2_addr));
        chk("write_count", WriteCount, mcnt);
    endtask

    task automatic apply(input logic [4:0] ctl, input logic [4:0] dst, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] a1, input logic [4:0] a2);
        WB_control = ctl; RegDst = dst; ReadData = rd; ALUResult = alu; RS1_addr = a1; RS2_addr = a2;
        #1;
        compare_all();
    endtask

    task automatic tick();
        logic [31:0] v;
        logic        w;
        logic [4:0]  d;
        v = m_wb(); w = m_wen(); d = RegDst;
        @(posedge CLK);
        if (w && !RESET) begin
            mregs[d] = v;
            mcnt = mcnt + 1;
        end
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mcnt = 0;
        RESET = 1'b1;
        WB_control = 0; RegDst = 0; ReadData = 0; ALUResult = 0; RS1_addr = 0; RS2_addr = 0;
        repeat (2) @(negedge CLK);
        RS1_addr = 5'd9;
        #1;
        chk("reset_rs1", RS1_data, 32'h0);
        chk("reset_count", WriteCount, 32'h0);
        RESET = 1'b0;
        @(negedge CLK);

        apply(5'b01000, 5'd5, 32'h0, 32'h1234_5678, 5'd0, 5'd0);
        tick();
        apply(5'b00000, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        chk("lit_x5", RS1_data, 32'h1234_5678);
        chk("lit_cnt1", WriteCount, 32'd1);
        tick();

        apply(5'b00101, 5'd1, 32'h0000_80F0, 32'h0, 5'd0, 5'd0);
        chk("lit_lb", WB_data, 32'hFFFF_FFF0);
        apply(5'b00110, 5'd1, 32'h0000_80F0, 32'h0, 5'd0, 5'd0);
        chk("lit_lh", WB_data, 32'hFFFF_80F0);
        apply(5'b00111, 5'd1, 32'h0000_80F0, 32'h0, 5'd0, 5'd0);
        chk("lit_lbu", WB_data, 32'h0000_00F0);
        apply(5'b00100, 5'd1, 32'h0000_80F0, 32'h0, 5'd0, 5'd0);
        chk("lit_lw", WB_data, 32'h0000_80F0);
        apply(5'b10011, 5'd1, 32'h0000_80F0, 32'hCAFE_0001, 5'd0, 5'd0);
        chk("lit_alu_ignores_regsrc", WB_data, 32'hCAFE_0001);
        tick();

        apply(5'b01000, 5'd0, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0);
        chk("lit_x0_wen", {31'h0, WB_wen}, 32'h0);
        chk("lit_x0_rd", RS1_data | RS2_data, 32'h0);
        tick();
        apply(5'b00000, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        chk("lit_x0_cnt", WriteCount, 32'd1);
        tick();

        apply(5'b01000, 5'd7, 32'h0, 32'h1, 5'd0, 5'd0);
        tick();
        apply(5'b01000, 5'd7, 32'h0, 32'h2, 5'd7, 5'd7);
        chk("lit_byp1", RS1_data, 32'h2);
        chk("lit_byp2", RS2_data, 32'h2);
        tick();
        apply(5'b00000, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
        chk("lit_x7_after", RS1_data, 32'h2);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] d, a1, a2;
            d  = n[0] ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a1 = n[1] ? d : 5'($urandom_range(0, 7));
            a2 = n[2] ? a1 : 5'($urandom);
            apply(5'($urandom), d, $urandom, $urandom, a1, a2);
            tick();
        end

        apply(5'b01000, 5'd3, 32'h0, 32'hAA, 5'd0, 5'd0);
        tick();
        apply(5'b00000, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);
        chk("lit_x3", RS1_data, 32'hAA);
        #2;
        RESET = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mcnt = 0;
        #1;
        chk("lit_async_rs1", RS1_data, 32'h0);
        chk("lit_async_cnt", WriteCount, 32'h0);
        @(negedge CLK);
        apply(5'b01000, 5'd4, 32'h0, 32'h55, 5'd3, 5'd4);
        chk("lit_reset_bypass", RS2_data, 32'h55);
        tick();
        apply(5'b00000, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0);
        chk("lit_reset_lost", RS1_data, 32'h0);
        RESET = 1'b0;
        apply(5'b01000, 5'd9, 32'h0, 32'h77, 5'd0, 5'd0);
        tick();
        apply(5'b00000, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
        chk("lit_post_reset_cnt", WriteCount, 32'd1);
        chk("lit_post_reset_x9", RS1_data, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
